// File: rtl/dmem_arbiter_if.sv
// Request buses of both data-memory masters plus the single-cycle memory port,
// seen from the arbiter (slave) and from the requesters/memory side (master).
interface dmem_arbiter_if;
    logic        m0_req, m0_we, m0_lock, m0_ack, m0_err, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_ack, m1_err, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_add, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m0_ack, m0_err, m0_rdata, m0_rvalid,
        output m1_ack, m1_err, m1_rdata, m1_rvalid,
        output mem_add, mem_write_data, mem_memwrite, mem_memread,
        input  mem_read_data
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m0_ack, m0_err, m0_rdata, m0_rvalid,
        input  m1_ack, m1_err, m1_rdata, m1_rvalid,
        input  mem_add, mem_write_data, mem_memwrite, mem_memread,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between CPU (m0) and DMA/debug (m1).
// Define DMEM_ARB_LOCK_EN to honour mx_lock for up to MAX_LOCK back-to-back grants.
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 32,
    parameter int MAX_LOCK    = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    state_t      state, state_next;
    logic        last_served;
    logic        serve0, serve1, in_range0, in_range1;
    logic        elig0, elig1, lock_win0, lock_win1;
    logic [31:0] rdata0_q, rdata1_q;
    logic        rvalid0_q, rvalid1_q;

    assign in_range0 = bus.m0_addr < 32'(DEPTH_WORDS);
    assign in_range1 = bus.m1_addr < 32'(DEPTH_WORDS);

    // Reset masks the grant combinationally so nothing commits in the reset cycle.
    assign serve0 = (state == SERVE0) && !reset;
    assign serve1 = (state == SERVE1) && !reset;

`ifdef DMEM_ARB_LOCK_EN
    localparam int LW = $clog2(MAX_LOCK + 1);
    logic [LW-1:0] lock_cnt;
    logic          lock_ok;

    assign lock_ok   = lock_cnt < LW'(MAX_LOCK);
    assign lock_win0 = (state == SERVE0) && bus.m0_req && bus.m0_lock && lock_ok;
    assign lock_win1 = (state == SERVE1) && bus.m1_req && bus.m1_lock && lock_ok;

    always_ff @(posedge clk) begin
        if (reset)
            lock_cnt <= '0;
        else if (lock_win0 || lock_win1)
            lock_cnt <= lock_cnt + LW'(1);
        else
            lock_cnt <= '0;
    end
`else
    logic unused_lock;
    assign unused_lock = bus.m0_lock ^ bus.m1_lock;
    assign lock_win0   = 1'b0;
    assign lock_win1   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state <= state_next;
            if (state == SERVE0)
                last_served <= 1'b0;
            else if (state == SERVE1)
                last_served <= 1'b1;
        end
    end

    always_comb begin
        state_next         = IDLE;
        elig0              = bus.m0_req && (state != SERVE0);
        elig1              = bus.m1_req && (state != SERVE1);
        bus.m0_ack         = 1'b0;
        bus.m0_err         = 1'b0;
        bus.m1_ack         = 1'b0;
        bus.m1_err         = 1'b0;
        bus.mem_add        = '0;
        bus.mem_write_data = '0;
        bus.mem_memwrite   = 1'b0;
        bus.mem_memread    = 1'b0;

        // A live lock beats round-robin; otherwise the master not served last wins.
        if (lock_win0)
            state_next = SERVE0;
        else if (lock_win1)
            state_next = SERVE1;
        else if (elig0 && elig1)
            state_next = last_served ? SERVE0 : SERVE1;
        else if (elig0)
            state_next = SERVE0;
        else if (elig1)
            state_next = SERVE1;

        if (serve0) begin
            bus.m0_ack         = 1'b1;
            bus.m0_err         = !in_range0;
            bus.mem_add        = bus.m0_addr;
            bus.mem_write_data = bus.m0_wdata;
            bus.mem_memwrite   = bus.m0_we && in_range0;
            bus.mem_memread    = !bus.m0_we && in_range0;
        end else if (serve1) begin
            bus.m1_ack         = 1'b1;
            bus.m1_err         = !in_range1;
            bus.mem_add        = bus.m1_addr;
            bus.mem_write_data = bus.m1_wdata;
            bus.mem_memwrite   = bus.m1_we && in_range1;
            bus.mem_memread    = !bus.m1_we && in_range1;
        end
    end

    // Out-of-range reads return zero rather than whatever the memory drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= serve0 && !bus.m0_we;
            rvalid1_q <= serve1 && !bus.m1_we;
            if (serve0 && !bus.m0_we)
                rdata0_q <= in_range0 ? bus.mem_read_data : '0;
            if (serve1 && !bus.m1_we)
                rdata1_q <= in_range1 ? bus.mem_read_data : '0;
        end
    end

    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single transactions plus
// sequences for alternation, reset mid-transaction and (optionally) lock.
module tb_dmem_arbiter;
    typedef struct {
        logic        rst;
        logic [1:0]  io0;
        logic [31:0] addr0, wdata0;
        logic [1:0]  io1;
        logic [31:0] addr1, wdata1;
        logic [2:0]  f0;
        logic [31:0] rd0;
        logic [2:0]  f1;
        logic [31:0] rd1;
        logic [1:0]  strb;
        logic [31:0] madd, mwd;
        logic        mchk;
        logic [4:0]  caddr;
        logic [31:0] cdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_load;
    logic [31:0] mem [0:31];
    int          n_compared = 0;
    int          n_mismatched = 0;
    vec_t        vecs [21];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH_WORDS(32), .MAX_LOCK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        case (i)
            1:       return 32'hA5;
            2:       return 32'h1;
            3:       return 32'h0;
            4:       return 32'h3;
            default: return 32'h1000 + 32'(i);
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (bus.mem_memwrite) begin
            mem[bus.mem_add[4:0]] <= bus.mem_write_data;
        end
    end

    assign bus.mem_read_data = (bus.mem_add < 32'd32) ? mem[bus.mem_add[4:0]] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic l0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                         input logic [31:0] a1, input logic [31:0] d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset = v.rst;
        drive(v.io0[1], v.io0[0], 1'b0, v.addr0, v.wdata0, v.io1[1], v.io1[0], 1'b0, v.addr1, v.wdata1);
    endtask

    task automatic check_output(input vec_t v, input int i);
        check($sformatf("row%0d m0 ack/err/rvalid", i), 32'({bus.m0_ack, bus.m0_err, bus.m0_rvalid}), 32'(v.f0));
        check($sformatf("row%0d m0_rdata", i), bus.m0_rdata, v.rd0);
        check($sformatf("row%0d m1 ack/err/rvalid", i), 32'({bus.m1_ack, bus.m1_err, bus.m1_rvalid}), 32'(v.f1));
        check($sformatf("row%0d m1_rdata", i), bus.m1_rdata, v.rd1);
        check($sformatf("row%0d memwrite/memread", i), 32'({bus.mem_memwrite, bus.mem_memread}), 32'(v.strb));
        check($sformatf("row%0d mem_add", i), bus.mem_add, v.madd);
        check($sformatf("row%0d mem_write_data", i), bus.mem_write_data, v.mwd);
        if (v.mchk)
            check($sformatf("row%0d mem[%0d]", i, v.caddr), mem[v.caddr], v.cdata);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  k0, k1, run, gaps;
        logic got0, got1, seen1;

        // rst, {req,we}0, addr0, wdata0, {req,we}1, addr1, wdata1 | {ack,err,rv}0, rdata0, {ack,err,rv}1, rdata1, {wr,rd}, mem_add, mem_wdata, mem check
        vecs[0]  = '{1'b0, 2'b10, 32'd2, 32'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'd0, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[1]  = '{1'b0, 2'b10, 32'd2, 32'd0, 2'b00, 32'd0, 32'd0, 3'b100, 32'd0, 3'b000, 32'd0, 2'b01, 32'd2, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[2]  = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 3'b001, 32'd1, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[3]  = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'd1, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[4]  = '{1'b1, 2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'd1, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[5]  = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'd0, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[6]  = '{1'b0, 2'b10, 32'd1, 32'd0, 2'b11, 32'd3, 32'hDEAD, 3'b000, 32'd0, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[7]  = '{1'b0, 2'b10, 32'd1, 32'd0, 2'b11, 32'd3, 32'hDEAD, 3'b100, 32'd0, 3'b000, 32'd0, 2'b01, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[8]  = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b11, 32'd3, 32'hDEAD, 3'b001, 32'hA5, 3'b100, 32'd0, 2'b10, 32'd3, 32'hDEAD, 1'b0, 5'd0, 32'd0};
        vecs[9]  = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'hA5, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b1, 5'd3, 32'hDEAD};
        vecs[10] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b11, 32'd40, 32'h1234, 3'b000, 32'hA5, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[11] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b11, 32'd40, 32'h1234, 3'b000, 32'hA5, 3'b110, 32'd0, 2'b00, 32'd40, 32'h1234, 1'b0, 5'd0, 32'd0};
        vecs[12] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'hA5, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b1, 5'd8, 32'h1008};
        vecs[13] = '{1'b0, 2'b10, 32'h8000_0001, 32'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'hA5, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[14] = '{1'b0, 2'b10, 32'h8000_0001, 32'd0, 2'b00, 32'd0, 32'd0, 3'b110, 32'hA5, 3'b000, 32'd0, 2'b00, 32'h8000_0001, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[15] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 3'b001, 32'd0, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[16] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b10, 32'd31, 32'd0, 3'b000, 32'd0, 3'b000, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[17] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b10, 32'd31, 32'd0, 3'b000, 32'd0, 3'b100, 32'd0, 2'b01, 32'd31, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[18] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b10, 32'd32, 32'd0, 3'b000, 32'd0, 3'b001, 32'h101F, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[19] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b10, 32'd32, 32'd0, 3'b000, 32'd0, 3'b110, 32'h101F, 2'b00, 32'd32, 32'd0, 1'b0, 5'd0, 32'd0};
        vecs[20] = '{1'b0, 2'b00, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'd0, 3'b001, 32'd0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0};

        reset    = 1'b1;
        mem_load = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset acks/errs/rvalids", 32'({bus.m0_ack, bus.m0_err, bus.m0_rvalid, bus.m1_ack, bus.m1_err, bus.m1_rvalid}), 32'd0);
        check("reset rdata0", bus.m0_rdata, 32'd0);
        check("reset rdata1", bus.m1_rdata, 32'd0);
        check("reset mem strobes", 32'({bus.mem_memwrite, bus.mem_memread}), 32'd0);
        check("reset mem_add", bus.mem_add, 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        mem_load = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output(vecs[i], i);
        end

        $display("[TB] continuous requests from both masters");
        k0 = 0; k1 = 0; got0 = 1'b0; got1 = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'(10 + k0), 32'd0, 1'b1, 1'b1, 1'b0, 32'(16 + k1), 32'hC000 + 32'(k1));
        @(negedge clk);
        check("alt c0 acks", 32'({bus.m0_ack, bus.m1_ack}), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (got0) k0++;
            if (got1) k1++;
            drive(1'b1, 1'b0, 1'b0, 32'(10 + k0), 32'd0, 1'b1, 1'b1, 1'b0, 32'(16 + k1), 32'hC000 + 32'(k1));
            @(negedge clk);
            got0 = bus.m0_ack;
            got1 = bus.m1_ack;
            check($sformatf("alt c%0d acks", c), 32'({bus.m0_ack, bus.m1_ack}), (c % 2 == 1) ? 32'd2 : 32'd1);
            check($sformatf("alt c%0d strobe", c), 32'(bus.mem_memwrite | bus.mem_memread), 32'd1);
            check($sformatf("alt c%0d m0_rvalid", c), 32'(bus.m0_rvalid), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c % 2 == 0)
                check($sformatf("alt c%0d m0_rdata", c), bus.m0_rdata, 32'h100A + 32'(c / 2 - 1));
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("alt mem[%0d]", 16 + i), mem[16 + i], 32'hC000 + 32'(i));

        $display("[TB] reset during SERVE1 write and SERVE0 read");
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd4, 32'h55);
        @(negedge clk);
        check("rstw idle m1_ack", 32'(bus.m1_ack), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rstw m1 ack/err", 32'({bus.m1_ack, bus.m1_err}), 32'd0);
        check("rstw strobes", 32'({bus.mem_memwrite, bus.mem_memread}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("rstw after acks", 32'({bus.m0_ack, bus.m1_ack}), 32'd0);
        check("rstw mem[4]", mem[4], 32'h3);
        check("rstw m0_rdata cleared", bus.m0_rdata, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rstr m0_ack", 32'(bus.m0_ack), 32'd0);
        check("rstr memread", 32'(bus.mem_memread), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("rstr m0_rvalid dropped", 32'(bus.m0_rvalid), 32'd0);
        check("rstr m0_rdata", bus.m0_rdata, 32'd0);

        $display("[TB] m0 holds lock while m1 requests");
        run = 0; gaps = 0; seen1 = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'd6, 32'd0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!seen1) begin
                if (bus.m1_ack) seen1 = 1'b1;
                else if (bus.m0_ack) run++;
                else if (run > 0) gaps++;
            end
            @(posedge clk); #1;
            if (seen1)
                drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        check("lock m1 granted", 32'(seen1), 32'd1);
`ifdef DMEM_ARB_LOCK_EN
        check("lock m0 run length", 32'(run), 32'd5);
`else
        check("lock m0 run length", 32'(run), 32'd1);
`endif
        check("lock idle gaps", 32'(gaps), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-cycle data memory between the CPU load/store path (master 0) and a secondary requester such as a DMA or debug port (master 1). It samples requests, grants the memory to one master per cycle under round-robin, drives the memory's address, data and strobe inputs, and returns registered read data with a valid pulse. It sits between the requesters and the data memory instance. It also owns out-of-range address rejection.

## Interface
Parameters:
- DEPTH_WORDS, 32: number of valid memory words; the memory index is the word address.
- MAX_LOCK, 4: maximum consecutive locked grants to one master (used only with the lock feature).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  transaction request; held with its qualifiers until the matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  32  word address
- m0_wdata / m1_wdata  in  32  write data
- m0_lock / m1_lock  in  1  request to keep the grant for the next transaction
- m0_ack / m1_ack  out  1  the transaction is executing on memory this cycle
- m0_err / m1_err  out  1  asserted with ack when the address is ≥ DEPTH_WORDS
- m0_rdata / m1_rdata  out  32  registered read data
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse when rdata is valid
- mem_add  out  32  to memory address
- mem_write_data  out  32  to memory write data
- mem_memwrite  out  1  to memory write strobe
- mem_memread  out  1  to memory read enable
- mem_read_data  in  32  from memory, combinational read

## Operation
- State machine states are IDLE, SERVE0 and SERVE1; the state is registered.
- Next-state selection is evaluated every cycle over the eligible requests:
  - In SERVEx, master x's req is not eligible. Its current transaction is being acked, so the same master gets at most one transaction per 2 cycles unless locked.
  - If exactly one master is eligible, that master goes to SERVEx.
  - If both are eligible, the master not served last wins. The last-served pointer updates on every SERVE cycle.
  - If none is eligible, the next state is IDLE.
- In SERVEx:
  - mx_ack = 1.
  - mem_add = mx_addr and mem_write_data = mx_wdata.
  - mem_memwrite = mx_we & in_range.
  - mem_memread = ~mx_we & in_range.
  - in_range = (mx_addr < DEPTH_WORDS), computed as a full 32-bit unsigned compare.
- Out of range: mx_err = 1 with the ack, no strobe is asserted, and a read returns rdata = 0 with rvalid.
- Read capture: at the end of a SERVEx read cycle, mx_rdata ← mem_read_data (or 0 if out of range). mx_rvalid = 1 for the following cycle only.
- Outside SERVE, all mem_* outputs are 0.
- A write commits at the clock edge ending its SERVE cycle; there is no rvalid for writes.

## Timing
- Request-to-ack latency is 1 cycle minimum: req seen in cycle N gives ack in N+1 and, for a read, rvalid in N+2.
- When both masters request continuously, they alternate every cycle, giving 100% memory utilisation.
- Reset values: state IDLE, last-served = master 1 (so master 0 wins the first conflict), all acks/errs/rvalids 0, rdata 0, lock count 0, all mem_* 0.
- When reset is high, ack, err, mem_memwrite and mem_memread are forced to 0 combinationally, so no write commits in the reset cycle. An in-flight read is dropped and no rvalid is produced.
- A master dropping req before its ack is a protocol violation; there is no required behaviour.

## Configuration
- DMEM_ARB_LOCK_EN defined:
  - If mx_lock = 1 during a SERVEx cycle, master x's next req is eligible and wins over the other master, provided the lock count < MAX_LOCK.
  - The lock count increments on each locked continuation and clears whenever the grant changes or enters IDLE.
  - When the count reaches MAX_LOCK, normal round-robin applies for that decision.
- DMEM_ARB_LOCK_EN undefined: the lock ports exist but are ignored, and the lock counter is not built.

## Test plan
- Reset, then m0 reads addr 2 with memory word 2 = 1 → m0_ack in cycle 1, m0_rvalid in cycle 2 with m0_rdata = 0x1; m1 outputs stay 0.
- Both masters assert req in the same cycle after reset, m0 read addr 1 (0xA5) and m1 write addr 3 = 0xDEAD → m0 served first, m1 the next cycle, memory word 3 = 0xDEAD, m0_rdata = 0xA5.
- Both masters hold req for 8 cycles with new transactions after each ack → acks alternate m0, m1, m0, …; mem_memread or mem_memwrite is high every cycle.
- m1 writes addr 40 with DEPTH_WORDS = 32 → m1_ack and m1_err high together, mem_memwrite = 0, memory unchanged.
- With DMEM_ARB_LOCK_EN and MAX_LOCK = 4, m0 holds lock while m1 requests → exactly 5 consecutive m0 grants (the initial grant plus 4 locked continuations), then m1 is granted.
- Reset asserted during a SERVE1 write of 0x55 to addr 4 → no write (word 4 keeps its reset value 0x3), m1_ack = 0, state IDLE afterwards.
